// File: rtl/bp_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and
// the saturating update rule used by every per-entry counter.
package bp_pkg;

    // 2-bit direction counter states, strongly/weakly not-taken and taken
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_state_e;

    // Next counter value: step up on inc, down on dec, hold at the ends
    function automatic logic [1:0] sat_update(input logic [1:0] cur,
                                              input logic       inc,
                                              input logic       dec);
        logic [1:0] nxt;
        nxt = cur;
        if (inc && !dec) begin
            if (cur != CTR_ST) nxt = cur + 2'b01;
        end else if (dec && !inc) begin
            if (cur != CTR_SNT) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating direction counter with a parallel load used when a
// fresh branch is allocated into the owning entry.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter logic [1:0] RST_VAL = 2'b01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] ctr
);

    // Reset beats load, and load beats a training step
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr <= RST_VAL;
        end else if (load) begin
            ctr <= load_val;
        end else begin
            ctr <= sat_update(ctr, inc, dec);
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Fully associative branch target buffer with per-entry 2-bit counters.
// Fetch looks up combinationally; EX trains, allocates or drops entries at
// the next edge. There is no bypass, so fetch always sees pre-update state.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int         PC_W        = 5,
    parameter int         DEPTH       = 8,
    parameter logic [1:0] CTR_INIT_NT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] F_pc,
    input  logic            F_stall,
    input  logic            EX_brn,
    input  logic            EX_inval,
    input  logic [PC_W-1:0] EX_pc,
    input  logic [PC_W-1:0] EX_alu_out,
    input  logic            EX_true_taken,
    output logic            F_BP_hit,
    output logic            F_BP_taken,
    output logic [PC_W-1:0] F_BP_target_pc
);

    localparam int IDX_W = $clog2(DEPTH);

    logic            valid   [DEPTH];
    logic [PC_W-1:0] tags    [DEPTH];
    logic [PC_W-1:0] targets [DEPTH];
    logic [1:0]      ctr     [DEPTH];
    logic [IDX_W-1:0] rr_ptr;

    logic             f_hit;
    logic [IDX_W-1:0] f_idx;
    logic             ex_hit;
    logic [IDX_W-1:0] ex_idx;
    logic             have_free;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim;
    logic             alloc_en;
    logic [PC_W-1:0]  fall_through;

    // Fetch-side match; scanning downward leaves the lowest matching index
    always_comb begin
        f_hit = 1'b0;
        f_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == F_pc) begin
                f_hit = 1'b1;
                f_idx = IDX_W'(i);
            end
        end
    end

    // EX-side match plus the lowest free slot for a possible allocation
    always_comb begin
        ex_hit    = 1'b0;
        ex_idx    = '0;
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == EX_pc) begin
                ex_hit = 1'b1;
                ex_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign alloc_en     = EX_brn && !ex_hit;
    assign victim       = have_free ? free_idx : rr_ptr;
    assign fall_through = F_pc + {{(PC_W-1){1'b0}}, ~F_stall};

    assign F_BP_hit       = f_hit;
    assign F_BP_taken     = f_hit && ctr[f_idx][1];
    assign F_BP_target_pc = F_BP_taken ? targets[f_idx] : fall_through;

    // One direction counter per entry, trained only by the entry EX hits
    for (genvar g = 0; g < DEPTH; g++) begin : g_ctr
        bp_sat_counter #(
            .RST_VAL (CTR_INIT_NT)
        ) u_ctr (
            .clk      (clk),
            .rst      (rst),
            .inc      (EX_brn && ex_hit && ex_idx == IDX_W'(g) &&  EX_true_taken),
            .dec      (EX_brn && ex_hit && ex_idx == IDX_W'(g) && !EX_true_taken),
            .load     (alloc_en && victim == IDX_W'(g)),
            .load_val (EX_true_taken ? CTR_WT : CTR_INIT_NT),
            .ctr      (ctr[g])
        );
    end

    // Entry state: resolved branches win over invalidation; the round-robin
    // pointer only moves when a still-valid entry gets thrown out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid[i]   <= 1'b0;
                tags[i]    <= '0;
                targets[i] <= '0;
            end
            rr_ptr <= '0;
        end else if (EX_brn) begin
            if (ex_hit) begin
                if (EX_true_taken) targets[ex_idx] <= EX_alu_out;
            end else begin
                valid[victim]   <= 1'b1;
                tags[victim]    <= EX_pc;
                targets[victim] <= EX_alu_out;
                if (!have_free) rr_ptr <= rr_ptr + IDX_W'(1);
            end
        end else if (EX_inval && ex_hit) begin
            valid[ex_idx] <= 1'b0;
        end
    end

endmodule
